fibo_decode_stage: RTL and testbench

//  Registered, parametrised instruction-decode stage for the Fibonacci FSM datapath.
//  - Sits between instruction fetch and the ALU/register file.
//  - Decodes {opcode, operand1, operand2} into ALU/regfile controls behind valid/ready handshakes.
//  - Stalls on read-after-write hazards against writes not yet landed; counts issued and stalled cycles.

---
 rtl/fibo_decode_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_fibo_decode_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fibo_decode_stage.sv
// fibo_decode_stage
// Registered instruction-decode stage for the Fibonacci FSM datapath.
// This stage receives {opcode, operand1, operand2} from fetch through a
// valid/ready handshake. It drives registered ALU and register-file controls
// downstream through a second valid/ready handshake.
// A small shift-register scoreboard tracks writes that have issued but have
// not yet reached the register file. Any instruction that reads one of those
// registers is held back until the write has landed.

module fibo_decode_stage #(
    parameter int ADDR_W = 2,
    parameter int WB_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] operand1,
    input  logic [ADDR_W-1:0] operand2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        alu_opcode,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic [ADDR_W-1:0] wrt_addr,
    output logic              wrt_en,
    output logic              load_data,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  stall_count
);

    // Opcodes that need special treatment in decode.
    localparam logic [2:0] OP_NOP  = 3'b000;  // no read, no write
    localparam logic [2:0] OP_LOAD = 3'b100;  // writes loaded data, reads nothing
    localparam logic [2:0] OP_NOWB = 3'b101;  // reads operands, no writeback

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    // Output stage registers
    logic              out_valid_reg,  out_valid_next;
    logic [2:0]        alu_opcode_reg, alu_opcode_next;
    logic [ADDR_W-1:0] rd_addr1_reg,   rd_addr1_next;
    logic [ADDR_W-1:0] rd_addr2_reg,   rd_addr2_next;
    logic [ADDR_W-1:0] wrt_addr_reg,   wrt_addr_next;
    logic              wrt_en_reg,     wrt_en_next;
    logic              load_data_reg,  load_data_next;

    // Statistics counters
    logic [CNT_W-1:0]  instr_count_reg, instr_count_next;
    logic [CNT_W-1:0]  stall_count_reg, stall_count_next;

    // Pending-write scoreboard. Slot 0 holds the youngest write; slot WB_LAT-1 the oldest.
    logic [WB_LAT-1:0]             sb_valid_reg, sb_valid_next;
    logic [WB_LAT-1:0][ADDR_W-1:0] sb_addr_reg,  sb_addr_next;
    logic [WB_LAT-1:0]             sb_hit;

    // Decode of the incoming instruction
    logic dec_wrt_en;
    logic dec_load_data;
    logic dec_reads;

    // Handshake and hazard terms
    logic held_hit;
    logic hazard;
    logic capture;
    logic issue;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    // Turn the incoming opcode into write, load and read-operand flags.
    always_comb begin
        dec_wrt_en    = (opcode != OP_NOP) && (opcode != OP_NOWB);
        dec_load_data = (opcode == OP_LOAD);
        dec_reads     = (opcode != OP_NOP) && (opcode != OP_LOAD);
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    // Slot 0 takes the write that issues this cycle. Each older slot takes
    // the contents of its younger neighbour. An address is written into
    // slot 0 even when no write issues; the valid bit masks that address,
    // so it is never used.
    generate
        for (genvar gi = 0; gi < WB_LAT; gi++) begin : g_sb
            if (gi == 0) begin : g_head
                assign sb_valid_next[gi] = issue & wrt_en_reg;
                assign sb_addr_next[gi]  = wrt_addr_reg;
            end else begin : g_tail
                assign sb_valid_next[gi] = sb_valid_reg[gi-1];
                assign sb_addr_next[gi]  = sb_addr_reg[gi-1];
            end

            // Check whether either source operand matches this pending write.
            assign sb_hit[gi] = sb_valid_reg[gi] &
                                ((sb_addr_reg[gi] == operand1) |
                                 (sb_addr_reg[gi] == operand2));

            // Advance this slot every cycle. When the oldest slot moves on,
            // its write has landed in the register file.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sb_valid_reg[gi] <= 1'b0;
                    sb_addr_reg[gi]  <= '0;
                end else begin
                    sb_valid_reg[gi] <= sb_valid_next[gi];
                    sb_addr_reg[gi]  <= sb_addr_next[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hazard detection and handshakes
    // ------------------------------------------------------------------
    // A reading instruction must wait if it reads any register with a write
    // still in flight. That includes the write held in the output register,
    // which has not yet entered the scoreboard.
    always_comb begin
        held_hit = out_valid_reg & wrt_en_reg &
                   ((wrt_addr_reg == operand1) | (wrt_addr_reg == operand2));
        hazard   = in_valid & dec_reads & ((|sb_hit) | held_hit);
        in_ready = (~out_valid_reg | out_ready) & ~hazard & ~flush;
        capture  = in_valid & in_ready;
        issue    = out_valid_reg & out_ready;
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    // Load the output register on capture and hold it under backpressure.
    // Flush takes priority and empties the register. An instruction that
    // issues in the same cycle as a flush has already been counted.
    always_comb begin
        out_valid_next  = out_valid_reg;
        alu_opcode_next = alu_opcode_reg;
        rd_addr1_next   = rd_addr1_reg;
        rd_addr2_next   = rd_addr2_reg;
        wrt_addr_next   = wrt_addr_reg;
        wrt_en_next     = wrt_en_reg;
        load_data_next  = load_data_reg;

        if (capture) begin
            alu_opcode_next = opcode;
            rd_addr1_next   = operand1;
            rd_addr2_next   = operand2;
            wrt_addr_next   = operand1;
            wrt_en_next     = dec_wrt_en;
            load_data_next  = dec_load_data;
        end

        if (flush) begin
            out_valid_next = 1'b0;
        end else if (capture) begin
            out_valid_next = 1'b1;
        end else if (issue) begin
            out_valid_next = 1'b0;
        end
    end

    // Register the output stage and discard any in-flight instruction on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            alu_opcode_reg <= '0;
            rd_addr1_reg   <= '0;
            rd_addr2_reg   <= '0;
            wrt_addr_reg   <= '0;
            wrt_en_reg     <= 1'b0;
            load_data_reg  <= 1'b0;
        end else begin
            out_valid_reg  <= out_valid_next;
            alu_opcode_reg <= alu_opcode_next;
            rd_addr1_reg   <= rd_addr1_next;
            rd_addr2_reg   <= rd_addr2_next;
            wrt_addr_reg   <= wrt_addr_next;
            wrt_en_reg     <= wrt_en_next;
            load_data_reg  <= load_data_next;
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    // The issue count wraps on overflow. The stall count stops at all-ones.
    // A stall cycle that coincides with a flush is not counted.
    always_comb begin
        instr_count_next = instr_count_reg;
        stall_count_next = stall_count_reg;
        if (issue) begin
            instr_count_next = instr_count_reg + CNT_W'(1);
        end
        if (hazard && !flush && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_next = stall_count_reg + CNT_W'(1);
        end
    end

    // Register the counters and clear them on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count_reg <= '0;
            stall_count_reg <= '0;
        end else begin
            instr_count_reg <= instr_count_next;
            stall_count_reg <= stall_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Output ports
    // ------------------------------------------------------------------
    assign out_valid   = out_valid_reg;
    assign alu_opcode  = alu_opcode_reg;
    assign rd_addr1    = rd_addr1_reg;
    assign rd_addr2    = rd_addr2_reg;
    assign wrt_addr    = wrt_addr_reg;
    assign wrt_en      = wrt_en_reg;
    assign load_data   = load_data_reg;
    assign instr_count = instr_count_reg;
    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_fibo_decode_stage.sv
// tb_fibo_decode_stage
// Scoreboard bench for fibo_decode_stage (ADDR_W=2, WB_LAT=2, CNT_W=4).
// When an instruction is accepted, the bench pushes its expected decoded
// controls onto a queue. When the instruction issues, the bench pops the
// entry and compares it with the DUT outputs. Directed sequences exercise
// the RAW hazard, backpressure, flush, counter wrap/saturation and reset.

module tb_fibo_decode_stage;

    localparam int ADDR_W = 2;
    localparam int WB_LAT = 2;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] operand1;
    logic [ADDR_W-1:0] operand2;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        alu_opcode;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [ADDR_W-1:0] wrt_addr;
    logic              wrt_en;
    logic              load_data;
    logic [CNT_W-1:0]  instr_count;
    logic [CNT_W-1:0]  stall_count;

    fibo_decode_stage #(
        .ADDR_W (ADDR_W),
        .WB_LAT (WB_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .operand1    (operand1),
        .operand2    (operand2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_opcode  (alu_opcode),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .wrt_addr    (wrt_addr),
        .wrt_en      (wrt_en),
        .load_data   (load_data),
        .instr_count (instr_count),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] a1;
        logic [1:0] a2;
        logic       wen;
        logic       ld;
    } exp_t;

    exp_t exp_q[$];
    int   errors     = 0;
    int   checks     = 0;
    int   issue_seen = 0;

    // Counts one comparison and prints a FAIL line if it does not match.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decode, written directly from the opcode table.
    function automatic exp_t model_decode(input logic [2:0] op, input logic [1:0] a1,
                                          input logic [1:0] a2);
        exp_t e;
        e.op  = op;
        e.a1  = a1;
        e.a2  = a2;
        e.wen = !(op == 3'd0 || op == 3'd5);
        e.ld  = (op == 3'd4);
        return e;
    endfunction

    // Clear the scoreboard and issue tally on reset. An instruction captured
    // before reset never leaves the DUT, so its queue entry must go.
    always @(negedge rst_n) begin
        exp_q.delete();
        issue_seen = 0;
    end

    // Monitor at the falling edge. Each event seen here takes effect on the
    // following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                issue_seen++;
                if (exp_q.size() == 0) begin
                    chk("issue_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("alu_opcode", {29'd0, alu_opcode}, {29'd0, e.op});
                    chk("rd_addr1",   {30'd0, rd_addr1},   {30'd0, e.a1});
                    chk("rd_addr2",   {30'd0, rd_addr2},   {30'd0, e.a2});
                    chk("wrt_addr",   {30'd0, wrt_addr},   {30'd0, e.a1});
                    chk("wrt_en",     {31'd0, wrt_en},     {31'd0, e.wen});
                    chk("load_data",  {31'd0, load_data},  {31'd0, e.ld});
                    $display("issue op=%0d a1=%0d a2=%0d wen=%0d ld=%0d", alu_opcode,
                             rd_addr1, rd_addr2, wrt_en, load_data);
                end
            end else if (out_valid && flush) begin
                if (exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                end
                $display("flushed held instruction");
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_decode(opcode, operand1, operand2));
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and wait (bounded) for it to be accepted.
    // Returns the number of cycles the instruction was held off.
    task automatic send(input logic [2:0] op, input logic [1:0] a1, input logic [1:0] a2,
                        output int waited);
        waited   = 0;
        in_valid = 1'b1;
        opcode   = op;
        operand1 = a1;
        operand2 = a2;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited >= 50) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    int w;
    int cnt0;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        opcode    = '0;
        operand1  = '0;
        operand2  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr_cnt", {28'd0, instr_count}, 32'd0);
        chk("rst_stall_cnt", {28'd0, stall_count}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);

        // RAW hazard: the writer issues first, then the reader must wait WB_LAT cycles.
        send(3'b001, 2'd2, 2'd0, w);
        chk("raw_first_wait", w, 32'd0);
        tick();  // first instruction issues on this edge
        send(3'b010, 2'd0, 2'd2, w);
        chk("raw_stall_cycles", w, 32'd2);
        chk("raw_stall_count", {28'd0, stall_count}, 32'd2);

        // A load followed by a NOP does not stall, because the NOP reads nothing.
        send(3'b100, 2'd2, 2'd1, w);
        send(3'b000, 2'd2, 2'd2, w);
        chk("load_nop_wait", w, 32'd0);
        chk("load_nop_stall", {28'd0, stall_count}, 32'd2);
        repeat (4) tick();

        // Decode sweep of all opcodes with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 2'(i % 4), 2'((i + 1) % 4), w);
        end
        repeat (5) tick();
        chk("sweep_drained", exp_q.size(), 32'd0);
        chk("sweep_instr_count", {28'd0, instr_count}, 32'(issue_seen % 16));

        // Backpressure: hold a valid instruction for five cycles, then release it.
        out_ready = 1'b0;
        send(3'b011, 2'd1, 2'd3, w);
        cnt0 = issue_seen;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid",  {31'd0, out_valid}, 32'd1);
            chk("bp_alu_opcode", {29'd0, alu_opcode}, 32'd3);
            chk("bp_rd_addr1",   {30'd0, rd_addr1}, 32'd1);
            chk("bp_rd_addr2",   {30'd0, rd_addr2}, 32'd3);
            chk("bp_wrt_en",     {31'd0, wrt_en}, 32'd1);
            chk("bp_in_ready",   {31'd0, in_ready}, 32'd0);
            chk("bp_instr_count", {28'd0, instr_count}, 32'(cnt0 % 16));
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_count", {28'd0, instr_count}, 32'((cnt0 + 1) % 16));
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) tick();

        // Flush the held instruction. A later reader of its destination sees no hazard.
        out_ready = 1'b0;
        send(3'b001, 2'd3, 2'd0, w);
        cnt0  = issue_seen;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_instr_count", {28'd0, instr_count}, 32'(cnt0 % 16));
        send(3'b010, 2'd3, 2'd3, w);
        chk("flush_no_hazard", w, 32'd0);
        out_ready = 1'b1;
        repeat (4) tick();

        // Stall saturation: a held write to r2 blocks a reader of r2 for 20 cycles.
        out_ready = 1'b0;
        send(3'b001, 2'd2, 2'd0, w);
        in_valid = 1'b1;
        opcode   = 3'b011;
        operand1 = 2'd2;
        operand2 = 2'd2;
        repeat (20) tick();
        chk("stall_saturate", {28'd0, stall_count}, 32'd15);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("queue_empty", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of traffic.
        in_valid = 1'b1;
        opcode   = 3'b000;
        repeat (3) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_instr_cnt", {28'd0, instr_count}, 32'd0);
        chk("mid_rst_stall_cnt", {28'd0, stall_count}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Counter wrap: 17 issues with a 4-bit counter leave a count of 1.
        for (int i = 0; i < 17; i++) begin
            send(3'b000, 2'(i % 4), 2'd0, w);
        end
        repeat (2) tick();
        chk("wrap_instr_count", {28'd0, instr_count}, 32'd1);
        chk("wrap_stall_count", {28'd0, stall_count}, 32'd0);
        chk("wrap_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
